decode_sequencer: RTL and testbench
===================================

# decode_sequencer

Parametrised front end of the decode stage. It buffers fetched instructions in a small queue and sequences each one over the number of execute cycles it needs: 2 for JAL/JALR, 2 for taken branches, MUL_CYCLES/DIV_CYCLES for M-extension ops, and 1 otherwise. For each cycle it hands the downstream combinational decoder a micro-op: instruction word, PC and cycle index. It also performs the register-count and extension legality checks that the purely combinational decode cannot.

## Interface

Parameters:
- GP_REG_COUNT, 16: architectural registers. Legal values are 16 (RV32E) or 32 (RV32I).
- IBUF_DEPTH, 2: instruction queue entries. Must be a power of two, ≥2.
- EN_MULDIV, 0: 1 enables decode of OP opcode with funct7=7'h01.
- MUL_CYCLES, 4: execute cycles for MUL/MULH/MULHSU/MULHU. Range 1..15.
- DIV_CYCLES, 8: execute cycles for DIV/DIVU/REM/REMU. Range 1..15.

Ports:
- clk_i  in  1  clock. One clock domain; everything is sampled on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- fetch_valid_i  in  1  fetch offers an instruction.
- fetch_ready_o  out  1  queue can accept an instruction.
- fetch_instr_i  in  32  instruction word; compressed instructions arrive already expanded.
- fetch_pc_i  in  32  instruction address.
- fetch_compressed_i  in  1  instruction originated as 16-bit.
- fetch_illegal_c_i  in  1  compressed expansion failed.
- uop_valid_o  out  1  micro-op present.
- uop_ready_i  in  1  execute accepts the micro-op.
- uop_instr_o  out  32  head instruction word.
- uop_pc_o  out  32  head PC.
- uop_compressed_o  out  1  head compressed flag.
- uop_cycle_o  out  4  cycle index within the instruction, starting at 0.
- uop_last_o  out  1  this micro-op is the instruction's final cycle.
- uop_illegal_o  out  1  head instruction is illegal.
- branch_taken_i  in  1  branch evaluation result; meaningful during a branch cycle-0 handshake.
- flush_i  in  1  discard all queued and in-progress work.

## Operation

- **Queue:** circular FIFO with read/write pointers of width clog2(IBUF_DEPTH) and a count of width clog2(IBUF_DEPTH)+1.
  - Push when fetch_valid_i & fetch_ready_o.
  - fetch_ready_o = (count != IBUF_DEPTH). It is asserted even while a pop is pending; when full it stays low even during a pop.
- **Issue:** uop_valid_o = (count != 0). uop_* fields are driven combinationally from the head entry plus the cycle counter `cyc`.
- **Illegal:** uop_illegal_o is set when any of these holds:
  - fetch_illegal_c_i was set on the entry;
  - the opcode is not one of OPIMM, OP, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH, SYSTEM;
  - GP_REG_COUNT=16 and instr bit 11, 19 or 24 is set in a field the format uses (rd: all except STORE/BRANCH; rs1: all except LUI/AUIPC/JAL; rs2: OP/STORE/BRANCH);
  - OP with funct7=7'h01 while EN_MULDIV=0.
  
  An illegal instruction always issues as a single cycle with uop_last_o=1.
- **Cycle count `n`:**
  - JAL, JALR: 2.
  - BRANCH: 2 if taken, otherwise 1.
  - OP with funct7=7'h01 and funct3[2]=0: MUL_CYCLES.
  - OP with funct7=7'h01 and funct3[2]=1: DIV_CYCLES.
  - Everything else: 1.
- **uop_last_o:**
  - Non-branch instructions: uop_last_o = (cyc == n-1).
  - BRANCH at cyc=0: uop_last_o = ~branch_taken_i.
  - BRANCH at cyc=1: uop_last_o = 1.
- **Handshake:** a micro-op transfers when uop_valid_o & uop_ready_i.
  - Transfer with uop_last_o=0: cyc increments.
  - Transfer with uop_last_o=1: cyc returns to 0 and the head is popped.
  - No transfer: all uop_* outputs hold stable.
- **Flush:** flush_i clears the pointers, count and cyc at the edge. It has priority over any same-cycle push or pop; a same-cycle fetch or uop handshake is discarded.
- **Reset:** rst_i has priority over flush_i.

## Timing

- **Reset values:** count=0, pointers=0, cyc=0, so fetch_ready_o=1, uop_valid_o=0 and uop_cycle_o=0. Data outputs are don't-care while uop_valid_o=0.
- **Latency:** an instruction pushed at edge N appears on uop_* in cycle N+1. There is no bypass path from fetch to uop.
- **Throughput:** one single-cycle instruction per clock while the queue is non-empty and uop_ready_i=1.
- **Simultaneous push and pop:** count is unchanged; the new entry is written at the write pointer.
- **Pointer wrap:** both pointers wrap modulo IBUF_DEPTH.
- **branch_taken_i:** sampled only on a BRANCH cycle-0 transfer; ignored otherwise.
- **Stall mid-sequence:** uop_ready_i low mid-sequence freezes cyc.
- **Reset or flush mid-sequence:** the next issued micro-op starts at cyc 0.

## Test plan

1. **Reset and basic issue:** reset, then push ADDI (0x00100093) with uop_ready_i=1.
   - Required: uop_valid_o is 1 exactly one cycle after the push, with cycle 0, last=1, illegal=0.
   - Required: count returns to 0.
2. **Jump, then branch taken and not taken:** push JAL (0x008000EF), then BEQ (0x00000463).
   - JAL: issues cycle 0 (last=0), then cycle 1 (last=1).
   - BEQ with branch_taken_i=0: issues one micro-op with last=1.
   - BEQ repeated with branch_taken_i=1: issues cycles 0 and 1.
3. **Multi-cycle multiply and divide:** EN_MULDIV=1, MUL_CYCLES=4, DIV_CYCLES=8.
   - MUL (0x02208033): issues cycles 0..3, last only on 3.
   - DIV (0x0220C033): issues cycles 0..7.
   - EN_MULDIV=0: MUL issues once with illegal=1.
4. **Register-count legality:** GP_REG_COUNT=16, push ADD x16,x1,x2 (0x00208833).
   - Required: illegal=1 and single cycle.
   - With GP_REG_COUNT=32: illegal=0.
5. **Full queue and wrap:** IBUF_DEPTH=2, uop_ready_i=0, push 3 instructions.
   - Required: fetch_ready_o=0 after 2 pushes; the third is held off.
   - Release uop_ready_i and stream 10 instructions: PCs issue in push order across pointer wrap.
6. **Flush and reset priority:**
   - Assert flush_i during cycle 1 of a 4-cycle MUL with a concurrent fetch push: next cycle count=0 and uop_valid_o=0.
   - Assert rst_i and flush_i together: reset values result.

Source files
------------

// File: rtl/decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decode_sequencer
// Purpose  : Decode-stage front end. Buffers fetched instructions in a small
//            circular queue and sequences the head instruction over the
//            number of execute cycles it needs, presenting one micro-op per
//            cycle (instr, PC, cycle index, last flag). Also flags the
//            register-count and extension legality errors that the
//            downstream combinational decoder cannot see.
// Ports    :
//   clk_i, rst_i            clock / synchronous active-high reset
//   fetch_valid_i/ready_o   fetch handshake
//   fetch_instr_i, pc_i     expanded instruction word and address
//   fetch_compressed_i      instruction originated as 16-bit
//   fetch_illegal_c_i       compressed expansion failed
//   uop_valid_o/ready_i     micro-op handshake
//   uop_instr/pc/compressed head entry fields
//   uop_cycle_o             cycle index within the instruction
//   uop_last_o              final micro-op of the instruction
//   uop_illegal_o           head instruction is illegal
//   branch_taken_i          branch result, used on a branch cycle-0 transfer
//   flush_i                 discard all queued and in-progress work
// Revision : 1.0 - initial release
// ============================================================================
module decode_sequencer #(
    parameter int GP_REG_COUNT = 16,
    parameter int IBUF_DEPTH   = 2,
    parameter int EN_MULDIV    = 0,
    parameter int MUL_CYCLES   = 4,
    parameter int DIV_CYCLES   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_instr_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        fetch_compressed_i,
    input  logic        fetch_illegal_c_i,
    output logic        uop_valid_o,
    input  logic        uop_ready_i,
    output logic [31:0] uop_instr_o,
    output logic [31:0] uop_pc_o,
    output logic        uop_compressed_o,
    output logic [3:0]  uop_cycle_o,
    output logic        uop_last_o,
    output logic        uop_illegal_o,
    input  logic        branch_taken_i,
    input  logic        flush_i
);

    localparam int PTR_W = $clog2(IBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(IBUF_DEPTH);
    localparam logic [3:0]       c_mul_n      = 4'(MUL_CYCLES);
    localparam logic [3:0]       c_div_n      = 4'(DIV_CYCLES);

    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_system = 7'b1110011;

    // ------------------------------------------------------------------
    // Queue storage and control state
    // ------------------------------------------------------------------
    logic [31:0]      instr_mem_q [IBUF_DEPTH];
    logic [31:0]      pc_mem_q    [IBUF_DEPTH];
    logic             comp_mem_q  [IBUF_DEPTH];
    logic             illc_mem_q  [IBUF_DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [3:0]       cyc_q,    cyc_d;

    logic             w_push;
    logic             w_fire;
    logic             w_pop;

    // ------------------------------------------------------------------
    // Head-entry decode
    // ------------------------------------------------------------------
    logic [31:0] w_head_instr;
    logic [6:0]  w_opcode;
    logic        w_known_op;
    logic        w_uses_rd;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_reg_bad;
    logic        w_is_m;
    logic        w_illegal;
    logic [3:0]  w_n;

    assign w_head_instr     = instr_mem_q[rd_ptr_q];
    assign w_opcode         = w_head_instr[6:0];

    assign fetch_ready_o    = (count_q != c_full_count);
    assign uop_valid_o      = (count_q != '0);
    assign uop_instr_o      = w_head_instr;
    assign uop_pc_o         = pc_mem_q[rd_ptr_q];
    assign uop_compressed_o = comp_mem_q[rd_ptr_q];
    assign uop_cycle_o      = cyc_q;
    assign uop_illegal_o    = w_illegal;

    assign w_push = fetch_valid_i & fetch_ready_o;
    assign w_fire = uop_valid_o & uop_ready_i;
    assign w_pop  = w_fire & uop_last_o;

    always_comb begin
        w_known_op = (w_opcode == c_opc_opimm)  || (w_opcode == c_opc_op)    ||
                     (w_opcode == c_opc_lui)    || (w_opcode == c_opc_auipc) ||
                     (w_opcode == c_opc_jal)    || (w_opcode == c_opc_jalr)  ||
                     (w_opcode == c_opc_load)   || (w_opcode == c_opc_store) ||
                     (w_opcode == c_opc_branch) || (w_opcode == c_opc_system);

        // Register fields present in each format; the top bit of each
        // 5-bit index (11, 19, 24) selects x16..x31, absent on RV32E.
        w_uses_rd  = !((w_opcode == c_opc_store) || (w_opcode == c_opc_branch));
        w_uses_rs1 = !((w_opcode == c_opc_lui) || (w_opcode == c_opc_auipc) ||
                       (w_opcode == c_opc_jal));
        w_uses_rs2 = (w_opcode == c_opc_op) || (w_opcode == c_opc_store) ||
                     (w_opcode == c_opc_branch);

        w_reg_bad = (GP_REG_COUNT == 16) &&
                    ((w_uses_rd  && w_head_instr[11]) ||
                     (w_uses_rs1 && w_head_instr[19]) ||
                     (w_uses_rs2 && w_head_instr[24]));

        w_is_m    = (w_opcode == c_opc_op) && (w_head_instr[31:25] == 7'h01);

        w_illegal = illc_mem_q[rd_ptr_q] || !w_known_op || w_reg_bad ||
                    (w_is_m && (EN_MULDIV == 0));
    end

    // Cycle count and last-cycle flag. Illegal instructions always issue once.
    always_comb begin
        w_n = 4'd1;
        if (w_illegal) begin
            w_n = 4'd1;
        end else if ((w_opcode == c_opc_jal) || (w_opcode == c_opc_jalr)) begin
            w_n = 4'd2;
        end else if (w_is_m) begin
            w_n = w_head_instr[14] ? c_div_n : c_mul_n;
        end

        uop_last_o = 1'b1;
        if (w_illegal) begin
            uop_last_o = 1'b1;
        end else if (w_opcode == c_opc_branch) begin
            // Branch length is only known from the cycle-0 evaluation.
            uop_last_o = (cyc_q == 4'd0) ? ~branch_taken_i : 1'b1;
        end else begin
            uop_last_o = (cyc_q == (w_n - 4'd1));
        end
    end

    // ------------------------------------------------------------------
    // Next-state: pointers, occupancy and cycle counter
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        cyc_d    = cyc_q;

        if (flush_i) begin
            // Flush wins over any same-cycle push or micro-op transfer.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            cyc_d    = '0;
        end else begin
            if (w_fire) begin
                if (uop_last_o) begin
                    cyc_d    = '0;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cyc_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            cyc_q    <= cyc_d;
        end
    end

    // Payload storage needs no reset: entries are only read while counted.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i && !rst_i) begin
            instr_mem_q[wr_ptr_q] <= fetch_instr_i;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_i;
            comp_mem_q[wr_ptr_q]  <= fetch_compressed_i;
            illc_mem_q[wr_ptr_q]  <= fetch_illegal_c_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_sequencer
// Purpose  : Self-checking bench for decode_sequencer. Two instances with
//            different parameter sets; one is exercised at a time against a
//            queue-based reference model of the instruction stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_sequencer;

    // Instance 0: RV32E, depth 2, M enabled (4/8). Instance 1: RV32I, depth 4, M off.
    localparam int GPR   [2] = '{16, 32};
    localparam int DEPTH [2] = '{2, 4};
    localparam int MD    [2] = '{1, 0};
    localparam int MULN  [2] = '{4, 3};
    localparam int DIVN  [2] = '{8, 5};
    localparam logic [6:0] OPS [11] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67,
                                        7'h03, 7'h23, 7'h63, 7'h73, 7'h0B};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bit          comp;
        bit          illc;
    } ent_t;

    logic clk;
    logic [1:0]        rst, flush, fv, fcomp, fillc, urdy, btk;
    logic [1:0][31:0]  finstr, fpc;
    wire  [1:0]        fready, uvalid, ucomp, ulast, uill;
    wire  [1:0][31:0]  uinstr, upc;
    wire  [1:0][3:0]   ucycle;

    int   total = 0;
    int   bad   = 0;
    int   cur   = 0;
    ent_t mq[$];
    int   mcyc  = 0;
    bit   accepted = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    decode_sequencer #(
        .GP_REG_COUNT(16), .IBUF_DEPTH(2), .EN_MULDIV(1), .MUL_CYCLES(4), .DIV_CYCLES(8)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]),
        .fetch_valid_i(fv[0]), .fetch_ready_o(fready[0]),
        .fetch_instr_i(finstr[0]), .fetch_pc_i(fpc[0]),
        .fetch_compressed_i(fcomp[0]), .fetch_illegal_c_i(fillc[0]),
        .uop_valid_o(uvalid[0]), .uop_ready_i(urdy[0]),
        .uop_instr_o(uinstr[0]), .uop_pc_o(upc[0]),
        .uop_compressed_o(ucomp[0]), .uop_cycle_o(ucycle[0]),
        .uop_last_o(ulast[0]), .uop_illegal_o(uill[0]),
        .branch_taken_i(btk[0]), .flush_i(flush[0])
    );

    decode_sequencer #(
        .GP_REG_COUNT(32), .IBUF_DEPTH(4), .EN_MULDIV(0), .MUL_CYCLES(3), .DIV_CYCLES(5)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]),
        .fetch_valid_i(fv[1]), .fetch_ready_o(fready[1]),
        .fetch_instr_i(finstr[1]), .fetch_pc_i(fpc[1]),
        .fetch_compressed_i(fcomp[1]), .fetch_illegal_c_i(fillc[1]),
        .uop_valid_o(uvalid[1]), .uop_ready_i(urdy[1]),
        .uop_instr_o(uinstr[1]), .uop_pc_o(upc[1]),
        .uop_compressed_o(ucomp[1]), .uop_cycle_o(ucycle[1]),
        .uop_last_o(ulast[1]), .uop_illegal_o(uill[1]),
        .branch_taken_i(btk[1]), .flush_i(flush[1])
    );

    // ------------------------------------------------------------------
    // Reference model: legality and length straight from the ISA rules
    // ------------------------------------------------------------------
    function automatic bit m_illegal(logic [31:0] i, bit illc);
        logic [6:0] op;
        bit urd, urs1, urs2;
        op = i[6:0];
        if (illc) return 1'b1;
        if (!(op inside {7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h73}))
            return 1'b1;
        if (GPR[cur] == 16) begin
            urd  = !(op == 7'h23 || op == 7'h63);
            urs1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
            urs2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
            if ((urd && i[11]) || (urs1 && i[19]) || (urs2 && i[24])) return 1'b1;
        end
        if (op == 7'h33 && i[31:25] == 7'h01 && MD[cur] == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_len(logic [31:0] i, bit illc);
        if (m_illegal(i, illc)) return 1;
        case (i[6:0])
            7'h6F, 7'h67: return 2;
            7'h33:        return (i[31:25] == 7'h01) ? (i[14] ? DIVN[cur] : MULN[cur]) : 1;
            default:      return 1;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r      = $urandom;
        r[6:0] = OPS[$urandom_range(0, 10)];
        if (r[6:0] == 7'h33) begin
            case ($urandom_range(0, 2))
                0:       r[31:25] = 7'h00;
                1:       r[31:25] = 7'h20;
                default: r[31:25] = 7'h01;
            endcase
        end
        if ($urandom_range(0, 1) == 0) begin
            r[11] = 1'b0;
            r[19] = 1'b0;
            r[24] = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut=%0d observed=%h expected=%h", tag, cur, obs, exp);
        end
    endtask

    task automatic set_in(bit v, logic [31:0] ins, logic [31:0] pc, bit c, bit ic,
                          bit rdy, bit tk, bit fl, bit rs);
        fv = '0; finstr = '0; fpc = '0; fcomp = '0; fillc = '0;
        urdy = '0; btk = '0; flush = '0; rst = '0;
        fv[cur] = v; finstr[cur] = ins; fpc[cur] = pc; fcomp[cur] = c;
        fillc[cur] = ic; urdy[cur] = rdy; btk[cur] = tk; flush[cur] = fl; rst[cur] = rs;
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance it.
    task automatic step();
        bit   exp_v, exp_r, exp_last, ill;
        int   len;
        ent_t h, e;
        @(negedge clk);
        exp_v = (mq.size() != 0);
        exp_r = (mq.size() != DEPTH[cur]);
        exp_last = 1'b0;
        chk("fetch_ready", {31'd0, fready[cur]}, {31'd0, exp_r});
        chk("uop_valid",   {31'd0, uvalid[cur]}, {31'd0, exp_v});
        if (exp_v) begin
            h   = mq[0];
            ill = m_illegal(h.instr, h.illc);
            len = m_len(h.instr, h.illc);
            if (ill)                      exp_last = 1'b1;
            else if (h.instr[6:0] == 7'h63) exp_last = (mcyc == 0) ? !btk[cur] : 1'b1;
            else                          exp_last = (mcyc == len - 1);
            chk("uop_instr",   uinstr[cur], h.instr);
            chk("uop_pc",      upc[cur], h.pc);
            chk("uop_comp",    {31'd0, ucomp[cur]}, {31'd0, h.comp});
            chk("uop_cycle",   {28'd0, ucycle[cur]}, 32'(mcyc));
            chk("uop_illegal", {31'd0, uill[cur]}, {31'd0, ill});
            chk("uop_last",    {31'd0, ulast[cur]}, {31'd0, exp_last});
        end
        accepted = 1'b0;
        if (rst[cur] || flush[cur]) begin
            mq.delete();
            mcyc = 0;
        end else begin
            accepted = fv[cur] && exp_r;
            if (exp_v && urdy[cur]) begin
                if (exp_last) begin
                    h    = mq.pop_front();
                    mcyc = 0;
                end else begin
                    mcyc++;
                end
            end
            if (accepted) begin
                e.instr = finstr[cur]; e.pc = fpc[cur];
                e.comp  = fcomp[cur];  e.illc = fillc[cur];
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_instr(logic [31:0] ins, logic [31:0] pc, bit rdy, bit tk);
        int n = 0;
        do begin
            set_in(1'b1, ins, pc, 1'b0, 1'b0, rdy, tk, 1'b0, 1'b0);
            step();
            n++;
        end while (!accepted && n < 50);
        total++;
        assert (accepted) else begin
            bad++;
            $error("FAIL push_timeout dut=%0d observed=%0d expected=1", cur, accepted);
        end
    endtask

    task automatic drain(bit tk);
        int n = 0;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, tk, 1'b0, 1'b0);
        while (mq.size() != 0 && n < 200) begin
            step();
            n++;
        end
        total++;
        assert (mq.size() == 0) else begin
            bad++;
            $error("FAIL drain_timeout dut=%0d observed=%0d expected=0", cur, mq.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 2'b11; flush = '0; fv = '0; finstr = '0; fpc = '0;
        fcomp = '0; fillc = '0; urdy = '0; btk = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = '0;

        // Reset state on both instances
        for (int k = 0; k < 2; k++) begin
            cur = k;
            chk("rst_valid", {31'd0, uvalid[k]}, 32'd0);
            chk("rst_ready", {31'd0, fready[k]}, 32'd1);
            chk("rst_cycle", {28'd0, ucycle[k]}, 32'd0);
        end

        // Basic issue, jump, branch not taken / taken (RV32E instance)
        cur = 0;
        push_instr(32'h0010_0093, 32'h0000_0000, 1'b1, 1'b0);
        drain(1'b0);
        chk("addi_empty", {31'd0, uvalid[0]}, 32'd0);
        push_instr(32'h0080_00EF, 32'h0000_0004, 1'b1, 1'b0);
        drain(1'b0);
        push_instr(32'h0000_0463, 32'h0000_0008, 1'b1, 1'b0);
        drain(1'b0);
        push_instr(32'h0000_0463, 32'h0000_000C, 1'b1, 1'b1);
        drain(1'b1);

        // Multiply / divide, and x16 destination on RV32E
        push_instr(32'h0220_8033, 32'h0000_0010, 1'b1, 1'b0);
        drain(1'b0);
        push_instr(32'h0220_C033, 32'h0000_0014, 1'b1, 1'b0);
        drain(1'b0);
        push_instr(32'h0020_8833, 32'h0000_0018, 1'b1, 1'b0);
        drain(1'b0);

        // Full queue held off, then stream across pointer wrap
        set_in(1'b1, 32'h0010_0093, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 32'h0010_0093, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("full_ready", {31'd0, fready[0]}, 32'd0);
        set_in(1'b1, 32'h0010_0093, 32'h0000_0108, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        for (int i = 0; i < 10; i++) begin
            push_instr(32'h0010_0093, 32'h0000_0108 + 32'(4 * i), 1'b1, 1'b0);
        end
        drain(1'b0);

        // Flush during cycle 1 of a MUL with a concurrent fetch
        push_instr(32'h0220_8033, 32'h0000_0200, 1'b1, 1'b0);
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 32'h0010_0093, 32'h0000_0204, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk("flush_valid", {31'd0, uvalid[0]}, 32'd0);
        chk("flush_ready", {31'd0, fready[0]}, 32'd1);

        // Reset together with flush
        push_instr(32'h0220_8033, 32'h0000_0300, 1'b0, 1'b0);
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk("rstfl_valid", {31'd0, uvalid[0]}, 32'd0);
        chk("rstfl_ready", {31'd0, fready[0]}, 32'd1);
        chk("rstfl_cycle", {28'd0, ucycle[0]}, 32'd0);

        // RV32I instance with M disabled
        cur = 1;
        push_instr(32'h0220_8033, 32'h0000_0400, 1'b1, 1'b0);
        drain(1'b0);
        push_instr(32'h0020_8833, 32'h0000_0404, 1'b1, 1'b0);
        drain(1'b0);

        // Randomized traffic on both instances
        for (int k = 0; k < 2; k++) begin
            cur = k;
            for (int n = 0; n < 400; n++) begin
                set_in($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 39) == 0, $urandom_range(0, 96) == 0);
                step();
            end
            drain(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
